// File: rtl/risc_fetch_buffer.sv
// Instruction prefetch queue feeding the core's Fetch stage; keeps memory requests in order and credit-limited.
// Optional macro FETCH_BYPASS_EN: a response reaching an empty queue is shown on InstrF/PCF in its arrival cycle.
module risc_fetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            InstrValidF,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] pcf_hold;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   live;
    logic [CW-1:0]   outst_nx;
    logic [XLEN-1:0] rsp_pc;
    logic            accept;
    logic            rsp_fire;
    logic            rsp_live;
    logic            byp_show;
    logic            byp_take;
    logic            pop;
    logic            push;

    // Queued entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
    assign imem_req_valid = !rst && (({1'b0, count} + {1'b0, outst}) < DEPTH_C);
    assign imem_req_addr  = issue_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_fire = imem_rsp_valid && (outst != '0);
    assign rsp_live = rsp_fire && (drop == '0);

    // Live requests are the youngest ones, contiguous up to issue_pc-4, so the oldest sits live words back.
    assign live   = outst - drop;
    assign rsp_pc = issue_pc - (XLEN'(live) << 2);

`ifdef FETCH_BYPASS_EN
    assign byp_show = rsp_live && (count == '0);
`else
    assign byp_show = 1'b0;
`endif

    assign byp_take = byp_show && !StallF && !PCSrcE;
    assign pop      = (count != '0) && !StallF && !PCSrcE;
    assign push     = rsp_live && !PCSrcE && !byp_take;
    assign outst_nx = outst + CW'(accept) - CW'(rsp_fire);

    always_comb begin
        InstrValidF = 1'b0;
        InstrF      = NOP;
        PCF         = pcf_hold;
        if (count != '0) begin
            InstrValidF = 1'b1;
            InstrF      = q_instr[rd_ptr];
            PCF         = q_pc[rd_ptr];
        end else if (byp_show) begin
            InstrValidF = 1'b1;
            InstrF      = imem_rsp_data;
            PCF         = rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_pc <= RESET_PC;
            pcf_hold <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            outst    <= '0;
            drop     <= '0;
        end else begin
            pcf_hold <= PCF;
            outst    <= outst_nx;
            if (PCSrcE) begin
                // Everything still in flight after this edge belongs to the abandoned path.
                issue_pc <= PCTargetE;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= outst_nx;
            end else begin
                if (accept) issue_pc <= issue_pc + XLEN'(4);
                if (push)   wr_ptr   <= wr_ptr + AW'(1);
                if (pop)    rd_ptr   <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= rsp_pc;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (outst == '0)));

endmodule

// File: tb/tb_risc_fetch_buffer.sv
// Randomized bench for risc_fetch_buffer against a queue-based model of the fetch path and an in-order imem.
module tb_risc_fetch_buffer;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        InstrValidF;
    logic [31:0] InstrF;
    logic [31:0] PCF;

    int checks = 0;
    int errors = 0;

    risc_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .InstrValidF(InstrValidF), .InstrF(InstrF), .PCF(PCF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2468_ACE1;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = 32'hFFFF_FFF0;
            1:       t = $urandom() & 32'hFFFF_FFFC;
            2:       t = 32'h0000_0100;
            default: t = $urandom_range(4095) << 2;
        endcase
        return t;
    endfunction

    typedef struct packed { logic [31:0] pc; logic dead; } fl_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    fl_t         inf[$];   // requests the core has sent, oldest first
    logic [31:0] mq[$];    // PCs waiting in the queue, head first
    pend_t       pend[$];  // imem side: accepted addresses and earliest reply cycle

    initial begin
        int unsigned pr_ready, pr_stall, pr_redir, lat_max, pr_gap;
        logic [31:0] m_pc, m_last, exp_pc, exp_in;
        logic        exp_v, exp_rv, rsp_live, from_q, popped, acc;
        fl_t         f;
        int          lat;

        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        StallF = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = '0;
        pr_ready = 100; pr_stall = 0; pr_redir = 0; lat_max = 1; pr_gap = 0;
        m_pc = RPC;
        m_last = RPC;

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (c >= 100 && (c % 100) == 0) begin
                pr_ready = $urandom_range(100, 40);
                pr_stall = $urandom_range(60);
                pr_redir = $urandom_range(10);
                lat_max  = $urandom_range(4, 1);
                pr_gap   = $urandom_range(40);
            end
            rst = (c < 2) || (c == 1000) || (c == 1001);
            imem_req_ready = ($urandom_range(99) < pr_ready);
            if (c >= 2 && c < 7) imem_req_ready = 1'b0;
            StallF = ($urandom_range(99) < pr_stall);
            if ((c >= 40 && c < 46) || (c >= 85 && c <= 87)) StallF = 1'b1;
            PCSrcE = !rst && ($urandom_range(99) < pr_redir);
            PCTargetE = pick_target();
            if (c == 60) begin PCSrcE = 1'b1; PCTargetE = 32'h0000_0100; end
            if (c == 86) begin PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; end
            imem_rsp_valid = !rst && (pend.size() > 0) && (pend[0].due <= c) && ($urandom_range(99) >= pr_gap);
            imem_rsp_data  = imem_rsp_valid ? word_of(pend[0].addr) : $urandom();
            lat = (c < 50) ? 1 : (c < 100) ? 3 : int'($urandom_range(lat_max, 1));

            @(negedge clk);
            if (rst) begin
                if (c == 1 || c == 1001) begin
                    check("rst_req_valid", imem_req_valid, 1'b0);
                    check("rst_req_addr", imem_req_addr, RPC);
                    check("rst_instr_valid", InstrValidF, 1'b0);
                    check("rst_instr", InstrF, NOP);
                    check("rst_pcf", PCF, RPC);
                end
                inf.delete();
                mq.delete();
                pend.delete();
                m_pc = RPC;
                m_last = RPC;
            end else begin
                exp_rv   = (mq.size() + inf.size()) < DEPTH;
                rsp_live = imem_rsp_valid && (inf.size() > 0) && !inf[0].dead;
                from_q   = mq.size() > 0;
                if (from_q) begin
                    exp_v = 1'b1; exp_pc = mq[0]; exp_in = word_of(mq[0]);
                end else if (BYP && rsp_live) begin
                    exp_v = 1'b1; exp_pc = inf[0].pc; exp_in = word_of(inf[0].pc);
                end else begin
                    exp_v = 1'b0; exp_pc = m_last; exp_in = NOP;
                end

                check("req_valid", imem_req_valid, exp_rv);
                if (exp_rv) check("req_addr", imem_req_addr, m_pc);
                check("instr_valid", InstrValidF, exp_v);
                check("instr", InstrF, exp_in);
                check("pcf", PCF, exp_pc);

                acc    = exp_rv && imem_req_ready;
                popped = exp_v && !StallF && !PCSrcE;
                m_last = exp_pc;
                if (popped && from_q) void'(mq.pop_front());
                if (imem_rsp_valid) begin
                    f = inf.pop_front();
                    void'(pend.pop_front());
                    if (!f.dead && !PCSrcE && !(popped && !from_q)) mq.push_back(f.pc);
                end
                if (acc) begin
                    inf.push_back('{pc: m_pc, dead: 1'b0});
                    pend.push_back('{addr: m_pc, due: c + lat});
                    m_pc = m_pc + 32'd4;
                end
                if (PCSrcE) begin
                    mq.delete();
                    foreach (inf[i]) inf[i].dead = 1'b1;
                    m_pc = PCTargetE;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
